serial_slave_responder: RTL

Slave-side endpoint of the bit-serial system bus: the responder for transactions issued by master ports. It deserialises the in-memory address and write data driven by the bus mux, performs the access on a local synchronous memory, and serialises read data back to the master with svalid framing. One instance sits between the bus slave mux and each slave device memory.

---
 rtl/serial_slave_responder_pkg.sv | 23 ++
 rtl/serial_shift_rx.sv | 46 ++++
 rtl/serial_slave_responder.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/serial_slave_responder_pkg.sv
// Shared definitions for the bit-serial bus slave: state encoding, transfer mode
// constants and counter sizing. Every serial field travels LSB first (bit 0 on the wire first).
package serial_slave_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_WDATA = 3'd2,
        ST_WRITE = 3'd3,
        ST_RREQ  = 3'd4,
        ST_RWAIT = 3'd5,
        ST_RDATA = 3'd6
    } state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    // Counter wide enough to index the longer serial field without wrapping.
    function automatic int cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/serial_shift_rx.sv
// Serial-to-parallel receiver: each enabled bit lands at index [count], LSB first.
// The counter returns to zero once the last bit of the field has been taken.
module serial_shift_rx
    import serial_slave_responder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = cnt_width(WIDTH, WIDTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] data,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        cnt_d  = cnt_q;
        done   = en && (cnt_q == CNT_W'(WIDTH - 1));
        if (en) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    data_d[i] = din;
                end
            end
            cnt_d = done ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            data_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            data_q <= data_d;
        end
    end

    assign data = data_q;

endmodule

// File: rtl/serial_slave_responder.sv
// Slave endpoint of the bit-serial bus: receives address/write data serially,
// strobes the local memory, and streams read data back with svalid framing.
module serial_slave_responder
    import serial_slave_responder_pkg::*;
#(
    parameter int SLAVE_MEM_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH           = 8,
    parameter int READ_LATENCY         = 1
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            swdata,
    input  logic                            smode,
    input  logic                            mvalid,
    output logic                            srdata,
    output logic                            svalid,
    output logic                            sready,
    output logic [SLAVE_MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_wen,
    output logic                            mem_ren,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam int CNT_W = cnt_width(SLAVE_MEM_ADDR_WIDTH, DATA_WIDTH);

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  rd_sh_q, rd_sh_d;
    logic                   srdata_q, srdata_d;
    logic                   svalid_q, svalid_d;
    logic                   wen_q, wen_d;
    logic                   ren_q, ren_d;
    logic                   addr_en, data_en, addr_done, data_done;

    // Address bit 0 is taken in IDLE together with the mode, so the receiver is live there too.
    assign addr_en = mvalid && ((state_q == ST_IDLE) || (state_q == ST_ADDR));
    assign data_en = mvalid && (state_q == ST_WDATA);

    serial_shift_rx #(.WIDTH(SLAVE_MEM_ADDR_WIDTH), .CNT_W(CNT_W)) u_addr_rx (
        .clk  (clk),
        .rstn (rstn),
        .en   (addr_en),
        .din  (swdata),
        .data (mem_addr),
        .done (addr_done)
    );

    serial_shift_rx #(.WIDTH(DATA_WIDTH), .CNT_W(CNT_W)) u_data_rx (
        .clk  (clk),
        .rstn (rstn),
        .en   (data_en),
        .din  (swdata),
        .data (mem_wdata),
        .done (data_done)
    );

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        cnt_d    = cnt_q;
        rd_sh_d  = rd_sh_q;
        srdata_d = 1'b0;
        svalid_d = 1'b0;
        wen_d    = 1'b0;
        ren_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mvalid) begin
                    mode_d  = smode;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (addr_done) begin
                    if (mode_q == MODE_WRITE) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RREQ;
                        ren_d   = 1'b1;
                    end
                end
            end
            ST_WDATA: begin
                if (data_done) begin
                    state_d = ST_WRITE;
                    wen_d   = 1'b1;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            ST_RREQ: begin
                cnt_d   = CNT_W'(1);
                state_d = ST_RWAIT;
            end
            // cnt_q counts cycles since the read strobe; memory data is valid when it reaches the latency.
            ST_RWAIT: begin
                if (cnt_q == CNT_W'(READ_LATENCY)) begin
                    rd_sh_d  = mem_rdata;
                    srdata_d = mem_rdata[0];
                    svalid_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_RDATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RDATA: begin
                if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d    = cnt_q + CNT_W'(1);
                    rd_sh_d  = rd_sh_q >> 1;
                    srdata_d = rd_sh_q[1];
                    svalid_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_READ;
            cnt_q    <= '0;
            rd_sh_q  <= '0;
            srdata_q <= 1'b0;
            svalid_q <= 1'b0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            rd_sh_q  <= rd_sh_d;
            srdata_q <= srdata_d;
            svalid_q <= svalid_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
        end
    end

    assign srdata  = srdata_q;
    assign svalid  = svalid_q;
    assign mem_wen = wen_q;
    assign mem_ren = ren_q;
    assign sready  = (state_q == ST_IDLE);

endmodule
